// File: rtl/md5_pkg.sv
// Shared constants and types for the MD5 preimage match unit.
// The MD5 IV words are kept here so generator and core code share one definition.
package md5_pkg;

    localparam int LATENCY_DEF = 66;
    localparam int BLOCK_W     = 512;
    localparam int MSG_W       = 448;
    localparam int HASH_W      = 128;
    localparam int LEN_W       = 64;
    localparam int MAX_LEN     = 447;

    localparam logic [31:0] MD5_IV_A = 32'h67452301;
    localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
    localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
    localparam logic [31:0] MD5_IV_D = 32'h10325476;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_FOUND  = 2'd2
    } state_t;

    // The MD5 length field is stored little-endian in the last 8 bytes of the block.
    function automatic logic [63:0] byte_rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = x[8*(7-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/md5_match_unit_if.sv
// Candidate feed from md5core and result handshake toward the consumer.
interface md5_match_unit_if;
    import md5_pkg::*;

    logic                 feed_valid;
    logic [HASH_W-1:0]    hash_in;
    logic [BLOCK_W-1:0]   block_in;
    logic                 res_valid;
    logic                 res_ready;
    logic [MSG_W-1:0]     found_msg;
    logic [LEN_W-1:0]     found_len;

    modport master (
        output feed_valid, hash_in, block_in, res_ready,
        input  res_valid, found_msg, found_len
    );

    modport slave (
        input  feed_valid, hash_in, block_in, res_ready,
        output res_valid, found_msg, found_len
    );

endinterface

// File: rtl/md5_unpad.sv
// Recovers the original message and its bit length from a padded MD5 block.
module md5_unpad
    import md5_pkg::*;
(
    input  logic [BLOCK_W-1:0] block,
    output logic [MSG_W-1:0]   msg,
    output logic [LEN_W-1:0]   len,
    output logic               len_ok
);

    logic [MSG_W-1:0] body;
    logic [MSG_W-1:0] mask;
    logic [8:0]       sh;

    always_comb begin
        len    = byte_rev64(block[63:0]);
        len_ok = (len <= LEN_W'(MAX_LEN));
        body   = block[BLOCK_W-1:LEN_W];
        sh     = '0;
        mask   = '0;
        msg    = '0;
        // Shifting right by (448-L) drops the pad bit and right-aligns the message.
        if (len_ok) begin
            sh   = 9'(MSG_W) - len[8:0];
            mask = ~({MSG_W{1'b1}} << len[8:0]);
            msg  = (body >> sh) & mask;
        end
    end

endmodule

// File: rtl/md5_match_unit.sv
// Watches md5core output for a digest equal to the armed target and returns
// the unpadded message that produced it.
module md5_match_unit
    import md5_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [HASH_W-1:0] target,
    output logic              busy,
    output logic [31:0]       checked,
    md5_match_unit_if.slave   bus
);

    state_t               state;
    logic [LATENCY-1:0]   tag_line;
    logic                 tag;
    logic [HASH_W-1:0]    target_q;
    logic                 res_valid_q;
    logic [MSG_W-1:0]     found_msg_q;
    logic [LEN_W-1:0]     found_len_q;

    logic [MSG_W-1:0]     dec_msg;
    logic [LEN_W-1:0]     dec_len;
    logic                 dec_len_ok;
    logic                 hit;

    md5_unpad u_unpad (
        .block  (bus.block_in),
        .msg    (dec_msg),
        .len    (dec_len),
        .len_ok (dec_len_ok)
    );

    // Tag line shifts in every state so in-flight candidates stay aligned with md5core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_line <= '0;
        end else begin
            tag_line <= (tag_line << 1) | LATENCY'(bus.feed_valid);
        end
    end

    assign tag = tag_line[LATENCY-1];
    assign hit = tag && (bus.hash_in == target_q) && dec_len_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            target_q    <= '0;
            checked     <= '0;
            busy        <= 1'b0;
            res_valid_q <= 1'b0;
            found_msg_q <= '0;
            found_len_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SEARCH;
                        busy     <= 1'b1;
                        checked  <= '0;
                        target_q <= target;
                    end
                end
                ST_SEARCH: begin
                    if (tag && (checked != 32'hFFFF_FFFF)) begin
                        checked <= checked + 32'd1;
                    end
                    // A stop wins over a simultaneous hit: nothing is captured.
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (hit) begin
                        state       <= ST_FOUND;
                        busy        <= 1'b0;
                        res_valid_q <= 1'b1;
                        found_msg_q <= dec_msg;
                        found_len_q <= dec_len;
                    end
                end
                ST_FOUND: begin
                    if (bus.res_ready) begin
                        state       <= ST_IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.found_msg = found_msg_q;
    assign bus.found_len = found_len_q;

endmodule

// File: tb/tb_md5_match_unit.sv
// Bench for md5_match_unit: an md5core delay-line model feeds candidates and a
// scoreboard checks each result's timing and contents.
module tb_md5_match_unit;
    import md5_pkg::*;

    localparam int LAT = LATENCY_DEF;
    localparam logic [127:0] H_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] H_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [127:0] target = '0;
    logic         busy;
    logic [31:0]  checked;

    md5_match_unit_if bus();

    md5_match_unit #(.LATENCY(LAT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .target  (target),
        .busy    (busy),
        .checked (checked),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         fv;
        int           len;
        logic [447:0] msg;
        logic [127:0] hash;
        logic [127:0] tgt;
        logic         hit;
    } vec_t;

    typedef struct {
        int           due;
        logic [447:0] msg;
        logic [63:0]  len;
    } exp_t;

    vec_t         vecs[8];
    exp_t         sb_q[$];
    logic [127:0] hbuf[LAT];
    logic [511:0] bbuf[LAT];
    logic         gen_valid;
    logic [127:0] gen_hash;
    logic [511:0] gen_block;
    logic         prev_rv;
    logic [447:0] last_msg;
    logic [63:0]  last_len;
    int           cyc;
    int           n_vec;
    int           n_err;

    task automatic chk(input string name, input logic [447:0] act, input logic [447:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [447:0] mask_to(input logic [447:0] m, input int len);
        logic [447:0] one;
        one = 448'd1;
        if (len == 0) return '0;
        return m & ((one << len) - 448'd1);
    endfunction

    // Real MD5 layout: message left-aligned, a single 1 pad bit, length little-endian.
    function automatic logic [511:0] make_block(input logic [447:0] m, input int len);
        logic [447:0] body;
        logic [63:0]  l64;
        logic [63:0]  lf;
        body = (len >= 448) ? m : (m << (448 - len));
        if (len < 448) body[447 - len] = 1'b1;
        l64 = 64'(len);
        for (int i = 0; i < 8; i++) lf[8*i +: 8] = l64[8*(7-i) +: 8];
        return {body, lf};
    endfunction

    task automatic monitor();
        exp_t e;
        if (bus.res_valid && !prev_rv) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_res_valid", 448'(bus.res_valid), 448'(0));
            end else begin
                e = sb_q.pop_front();
                chk("res_latency", 448'(cyc), 448'(e.due));
                chk("found_msg", bus.found_msg, e.msg);
                chk("found_len", 448'(bus.found_len), 448'(e.len));
            end
        end
        prev_rv = bus.res_valid;
    endtask

    // One clock: present this cycle's candidate and the hash/block md5core finished now.
    task automatic step();
        int k;
        k = cyc % LAT;
        bus.feed_valid = gen_valid;
        bus.hash_in    = hbuf[k];
        bus.block_in   = bbuf[k];
        hbuf[k] = gen_hash;
        bbuf[k] = gen_block;
        @(posedge clk);
        #1;
        cyc++;
        gen_valid = 1'b0;
        gen_hash  = '0;
        gen_block = '0;
        monitor();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic feed(input logic fv, input logic [447:0] m, input int len,
                        input logic [127:0] h, input logic exp_hit);
        exp_t e;
        gen_valid = fv;
        gen_hash  = h;
        gen_block = make_block(m, len);
        if (exp_hit) begin
            e.due = cyc + LAT + 1;
            e.msg = mask_to(m, len);
            e.len = 64'(len);
            sb_q.push_back(e);
        end
        step();
    endtask

    task automatic arm(input logic [127:0] t);
        start  = 1'b1;
        target = t;
        step();
        start  = 1'b0;
        target = ~t;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        prev_rv = 1'b0;
        gen_valid = 1'b0;
        gen_hash = '0;
        gen_block = '0;
        last_msg = '0;
        last_len = '0;
        for (int i = 0; i < LAT; i++) begin
            hbuf[i] = '0;
            bbuf[i] = '0;
        end
        bus.feed_valid = 1'b0;
        bus.hash_in = '0;
        bus.block_in = '0;
        bus.res_ready = 1'b1;

        vecs[0] = '{1'b1, 24,  448'h616263, H_ABC, H_ABC, 1'b1};
        vecs[1] = '{1'b1, 0,   448'h0, H_EMPTY, H_EMPTY, 1'b1};
        vecs[2] = '{1'b1, 24,  448'h616263, H_ABC, H_EMPTY, 1'b0};
        vecs[3] = '{1'b1, 447, {7{64'h0123456789abcdef}}, {8{16'h1111}}, {8{16'h1111}}, 1'b1};
        vecs[4] = '{1'b1, 448, {7{64'h0123456789abcdef}}, {8{16'h1111}}, {8{16'h1111}}, 1'b0};
        vecs[5] = '{1'b0, 24,  448'h616263, H_ABC, H_ABC, 1'b0};
        vecs[6] = '{1'b1, 440, {56{8'h5a}}, {8{16'h2222}}, {8{16'h2222}}, 1'b1};
        vecs[7] = '{1'b1, 8,   448'h41, {8{16'h3333}}, {8{16'h3334}}, 1'b0};

        // Reset state
        steps(2);
        chk("rst_busy", 448'(busy), 448'(0));
        chk("rst_res_valid", 448'(bus.res_valid), 448'(0));
        chk("rst_checked", 448'(checked), 448'(0));
        chk("rst_found_msg", bus.found_msg, 448'(0));
        chk("rst_found_len", 448'(bus.found_len), 448'(0));
        rst_n = 1'b1;
        step();

        // Table-driven single-candidate searches
        for (int i = 0; i < 8; i++) begin
            arm(vecs[i].tgt);
            chk("armed_busy", 448'(busy), 448'(1));
            chk("armed_checked", 448'(checked), 448'(0));
            feed(vecs[i].fv, vecs[i].msg, vecs[i].len, vecs[i].hash, vecs[i].hit);
            steps(LAT);
            chk("vec_checked", 448'(checked), 448'(vecs[i].fv));
            chk("vec_res_valid", 448'(bus.res_valid), 448'(vecs[i].hit));
            chk("vec_busy", 448'(busy), 448'(!vecs[i].hit));
            if (vecs[i].hit) begin
                last_msg = mask_to(vecs[i].msg, vecs[i].len);
                last_len = 64'(vecs[i].len);
                step();
                chk("after_ack_res_valid", 448'(bus.res_valid), 448'(0));
                chk("after_ack_busy", 448'(busy), 448'(0));
            end else begin
                stop = 1'b1;
                step();
                stop = 1'b0;
                chk("after_stop_busy", 448'(busy), 448'(0));
            end
            chk("retained_msg", bus.found_msg, last_msg);
            chk("retained_len", 448'(bus.found_len), 448'(last_len));
        end

        // 1000 non-matching candidates, then stop
        arm(H_ABC);
        for (int i = 0; i < 1000; i++) feed(1'b1, 448'h616263, 24, 128'(i + 1), 1'b0);
        steps(LAT);
        chk("stream_checked", 448'(checked), 448'(1000));
        chk("stream_busy", 448'(busy), 448'(1));
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stream_stop_busy", 448'(busy), 448'(0));
        chk("stream_checked_kept", 448'(checked), 448'(1000));

        // Result held with res_ready low; start/stop must be ignored in FOUND
        bus.res_ready = 1'b0;
        arm(H_ABC);
        feed(1'b1, 448'h616263, 24, H_ABC, 1'b1);
        steps(LAT);
        for (int i = 0; i < 20; i++) begin
            stop  = (i == 5);
            start = (i == 10);
            step();
            chk("hold_res_valid", 448'(bus.res_valid), 448'(1));
            chk("hold_busy", 448'(busy), 448'(0));
            chk("hold_msg", bus.found_msg, 448'h616263);
            chk("hold_len", 448'(bus.found_len), 448'(24));
        end
        stop = 1'b0;
        start = 1'b0;
        bus.res_ready = 1'b1;
        step();
        chk("release_res_valid", 448'(bus.res_valid), 448'(0));
        chk("release_busy", 448'(busy), 448'(0));
        last_msg = 448'h616263;
        last_len = 64'd24;

        // stop in the exact cycle of a hit: nothing captured
        arm(H_EMPTY);
        feed(1'b1, 448'h0, 0, H_EMPTY, 1'b0);
        steps(LAT - 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stophit_busy", 448'(busy), 448'(0));
        chk("stophit_res_valid", 448'(bus.res_valid), 448'(0));
        chk("stophit_checked", 448'(checked), 448'(1));
        steps(4);
        chk("stophit_msg", bus.found_msg, last_msg);
        chk("stophit_len", 448'(bus.found_len), 448'(last_len));

        // Reset mid-search with a matching candidate in flight
        arm(H_ABC);
        feed(1'b1, 448'h616263, 24, H_ABC, 1'b0);
        steps(10);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 448'(busy), 448'(0));
        steps(2);
        chk("midrst_checked", 448'(checked), 448'(0));
        chk("midrst_found_msg", bus.found_msg, 448'(0));
        chk("midrst_found_len", 448'(bus.found_len), 448'(0));
        rst_n = 1'b1;
        steps(LAT + 5);
        chk("midrst_res_valid", 448'(bus.res_valid), 448'(0));
        chk("midrst_busy", 448'(busy), 448'(0));
        chk("midrst_checked_after", 448'(checked), 448'(0));

        chk("scoreboard_empty", 448'(sb_q.size()), 448'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
